// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with valid/ready handshake, flush, and a
// fixed-latency hold sequencer for RV32M ops that stalls upstream while busy.
module alu_decode_stage #(
  parameter int ALUOP_WIDTH = 3,
  parameter int OP_WIDTH    = 7,
  parameter int F3_WIDTH    = 3,
  parameter int F7_WIDTH    = 7,
  parameter int CTRL_WIDTH  = 4,
  parameter int MD_LATENCY  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [F3_WIDTH-1:0]    funct3,
  input  logic [F7_WIDTH-1:0]    funct7,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [CTRL_WIDTH-1:0]  alu_ctrl,
  output logic                   a_type,
  output logic [F3_WIDTH-1:0]    md_op,
  output logic                   md_start,
  output logic                   md_busy,
  output logic                   illegal
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);
  localparam bit MD_SINGLE = (MD_LATENCY == 1);

  localparam logic [CTRL_WIDTH-1:0] CTRL_ADD = CTRL_WIDTH'(4'd0);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SUB = CTRL_WIDTH'(4'd1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SLL = CTRL_WIDTH'(4'd2);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SLT = CTRL_WIDTH'(4'd3);
  localparam logic [CTRL_WIDTH-1:0] CTRL_XOR = CTRL_WIDTH'(4'd4);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SRL = CTRL_WIDTH'(4'd5);
  localparam logic [CTRL_WIDTH-1:0] CTRL_OR  = CTRL_WIDTH'(4'd6);
  localparam logic [CTRL_WIDTH-1:0] CTRL_AND = CTRL_WIDTH'(4'd7);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SRA = CTRL_WIDTH'(4'd8);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SLTU = CTRL_WIDTH'(4'd9);
  localparam logic [CTRL_WIDTH-1:0] CTRL_LUI = CTRL_WIDTH'(4'd10);
  localparam logic [CTRL_WIDTH-1:0] CTRL_MD  = CTRL_WIDTH'(4'd11);

  localparam logic [F7_WIDTH-1:0] F7_ZERO = '0;
  localparam logic [F7_WIDTH-1:0] F7_ALT  = F7_WIDTH'(7'b0100000);
  localparam logic [F7_WIDTH-1:0] F7_MD   = F7_WIDTH'(7'b0000001);

  localparam logic [ALUOP_WIDTH-1:0] AOP_ALU   = ALUOP_WIDTH'(3'd0);
  localparam logic [ALUOP_WIDTH-1:0] AOP_LOAD  = ALUOP_WIDTH'(3'd1);
  localparam logic [ALUOP_WIDTH-1:0] AOP_STORE = ALUOP_WIDTH'(3'd2);
  localparam logic [ALUOP_WIDTH-1:0] AOP_BR    = ALUOP_WIDTH'(3'd3);
  localparam logic [ALUOP_WIDTH-1:0] AOP_LUI   = ALUOP_WIDTH'(3'd5);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_MDWAIT} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  out_valid_reg, out_valid_next;
  logic [CTRL_WIDTH-1:0] ctrl_reg, ctrl_next;
  logic                  a_type_reg, a_type_next;
  logic [F3_WIDTH-1:0]   md_op_reg, md_op_next;
  logic                  md_start_reg, md_start_next;
  logic                  md_busy_reg, md_busy_next;
  logic                  illegal_reg, illegal_next;

  logic [CTRL_WIDTH-1:0] dec_ctrl;
  logic                  dec_a_type, dec_md, dec_illegal;
  logic [F3_WIDTH-1:0]   dec_md_op;
  logic                  is_r, accept;
  logic                  unused_op;

  // op[5] separates register-register from immediate forms; other opcode bits are not needed here
  assign is_r      = op[5];
  assign unused_op = ^{op[OP_WIDTH-1:6], op[4:0]};

  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_a_type  = 1'b0;
    dec_md      = 1'b0;
    dec_md_op   = '0;
    dec_illegal = 1'b0;
    case (alu_op)
      AOP_ALU: begin
        if (is_r && funct7 == F7_MD) begin
          dec_md    = 1'b1;
          dec_ctrl  = CTRL_MD;
          dec_md_op = funct3;
        end else begin
          if (is_r)
            dec_illegal = !((funct7 == F7_ZERO) ||
                            (funct7 == F7_ALT && (funct3 == F3_WIDTH'(0) || funct3 == F3_WIDTH'(5))));
          else
            dec_illegal = (funct3 == F3_WIDTH'(1) && funct7 != F7_ZERO) ||
                          (funct3 == F3_WIDTH'(5) && funct7 != F7_ZERO && funct7 != F7_ALT);
          // illegal encodings fall through as add
          if (!dec_illegal) begin
            case (funct3)
              F3_WIDTH'(0): dec_ctrl = (is_r && funct7[5]) ? CTRL_SUB : CTRL_ADD;
              F3_WIDTH'(1): dec_ctrl = CTRL_SLL;
              F3_WIDTH'(2): dec_ctrl = CTRL_SLT;
              F3_WIDTH'(3): dec_ctrl = CTRL_SLTU;
              F3_WIDTH'(4): dec_ctrl = CTRL_XOR;
              F3_WIDTH'(5): dec_ctrl = funct7[5] ? CTRL_SRA : CTRL_SRL;
              F3_WIDTH'(6): dec_ctrl = CTRL_OR;
              default:      dec_ctrl = CTRL_AND;
            endcase
          end
        end
      end
      AOP_LOAD:  dec_a_type = (funct3 == F3_WIDTH'(4));
      AOP_STORE: dec_a_type = (funct3 == F3_WIDTH'(0));
      AOP_BR:    dec_ctrl   = CTRL_SUB;
      AOP_LUI:   dec_ctrl   = CTRL_LUI;
      default:   dec_ctrl   = CTRL_ADD;
    endcase
  end

  assign in_ready = !rst && !flush &&
                    (state_reg == ST_IDLE || (state_reg == ST_HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    ctrl_next      = ctrl_reg;
    a_type_next    = a_type_reg;
    md_op_next     = md_op_reg;
    md_start_next  = 1'b0;
    md_busy_next   = md_busy_reg;
    illegal_next   = illegal_reg;
    if (flush) begin
      state_next     = ST_IDLE;
      out_valid_next = 1'b0;
      md_busy_next   = 1'b0;
      cnt_next       = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (out_ready) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
          end
        end
        ST_MDWAIT: begin
          if (cnt_reg == '0) begin
            state_next     = ST_HOLD;
            out_valid_next = 1'b1;
            md_busy_next   = 1'b0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: state_next = state_reg;
      endcase
      if (accept) begin
        ctrl_next    = dec_ctrl;
        a_type_next  = dec_a_type;
        md_op_next   = dec_md_op;
        illegal_next = dec_illegal;
        if (dec_md) begin
          md_start_next = 1'b1;
          // a single-cycle unit completes immediately, so the busy phase is skipped
          if (MD_SINGLE) begin
            state_next     = ST_HOLD;
            out_valid_next = 1'b1;
            md_busy_next   = 1'b0;
            cnt_next       = '0;
          end else begin
            state_next     = ST_MDWAIT;
            out_valid_next = 1'b0;
            md_busy_next   = 1'b1;
            cnt_next       = CNT_W'(MD_LATENCY - 1);
          end
        end else begin
          state_next     = ST_HOLD;
          out_valid_next = 1'b1;
          md_busy_next   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
      a_type_reg    <= 1'b0;
      md_op_reg     <= '0;
      md_start_reg  <= 1'b0;
      md_busy_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      ctrl_reg      <= ctrl_next;
      a_type_reg    <= a_type_next;
      md_op_reg     <= md_op_next;
      md_start_reg  <= md_start_next;
      md_busy_reg   <= md_busy_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign alu_ctrl  = ctrl_reg;
  assign a_type    = a_type_reg;
  assign md_op     = md_op_reg;
  assign md_start  = md_start_reg;
  assign md_busy   = md_busy_reg;
  assign illegal   = illegal_reg;

endmodule
